// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with arbitrary depth, standard or FWFT read port, occupancy count and thresholds.
// Standard reads return data one cycle after rden; full/empty gate requests and rejected ones pulse overflow/underflow.
module sync_fifo_ext #(
   parameter int DWIDTH   = 8,
   parameter int DEPTH    = 16,
   parameter int FWFT     = 0,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   parameter int CWIDTH   = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              wren,
   input  logic [DWIDTH-1:0] din,
   input  logic              rden,
   output logic [DWIDTH-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [CWIDTH-1:0] count,
   output logic              overflow,
   output logic              underflow
);

   localparam int                PWIDTH  = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam logic [CWIDTH-1:0] DEPTH_C = CWIDTH'(DEPTH);
   localparam logic [CWIDTH-1:0] AF_C    = CWIDTH'(AF_LEVEL);
   localparam logic [CWIDTH-1:0] AE_C    = CWIDTH'(AE_LEVEL);
   localparam logic [PWIDTH-1:0] LAST_C  = PWIDTH'(DEPTH - 1);

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [PWIDTH-1:0] wptr;
   logic [PWIDTH-1:0] rptr;
   logic [PWIDTH-1:0] wptr_nxt;
   logic [PWIDTH-1:0] rptr_nxt;
   logic [CWIDTH-1:0] count_nxt;
   logic              wr_acc;
   logic              rd_acc;

   // Flags decode only the registered count, so no request reaches them combinationally.
   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);

   assign wr_acc = wren && !full;
   assign rd_acc = rden && !empty;

   // Explicit wrap keeps non-power-of-two depths correct.
   assign wptr_nxt = (wptr == LAST_C) ? '0 : wptr + 1'b1;
   assign rptr_nxt = (rptr == LAST_C) ? '0 : rptr + 1'b1;

   always_comb begin
      count_nxt = count;
      case ({wr_acc, rd_acc})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wptr <= wptr_nxt;
         if (rd_acc) rptr <= rptr_nxt;
         count     <= count_nxt;
         overflow  <= wren && full;
         underflow <= rden && empty;
      end
   end

   // Storage is deliberately left unreset; count alone defines what is valid.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wptr] <= din;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign dout = empty ? '0 : mem[rptr];
      end else begin : g_std
         logic [DWIDTH-1:0] dout_q;

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)       dout_q <= '0;
            else if (rd_acc) dout_q <= mem[rptr];
         end

         assign dout = dout_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Drives one standard-mode and one FWFT instance with identical traffic and checks both against a queue model.
module tb_sync_fifo_ext;

   localparam int DW = 8;
   localparam int DP = 5;
   localparam int AF = 3;
   localparam int AE = 1;
   localparam int CW = $clog2(DP + 1);

   logic          clk  = 1'b0;
   logic          rstn = 1'b1;
   logic          wren = 1'b0;
   logic          rden = 1'b0;
   logic [DW-1:0] din  = '0;

   logic [DW-1:0] s_dout, f_dout;
   logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
   logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
   logic [CW-1:0] s_count, f_count;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout = '0;
   bit            m_ovf  = 1'b0;
   bit            m_unf  = 1'b0;

   always #5 clk = ~clk;

   sync_fifo_ext #(.DWIDTH(DW), .DEPTH(DP), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_std (
      .clk(clk), .rstn(rstn), .wren(wren), .din(din), .rden(rden), .dout(s_dout),
      .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
      .count(s_count), .overflow(s_ovf), .underflow(s_unf)
   );

   sync_fifo_ext #(.DWIDTH(DW), .DEPTH(DP), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
      .clk(clk), .rstn(rstn), .wren(wren), .din(din), .rden(rden), .dout(f_dout),
      .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
      .count(f_count), .overflow(f_ovf), .underflow(f_unf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      int            n;
      logic [DW-1:0] head;
      n    = q.size();
      head = (n == 0) ? '0 : q[0];
      chk("s_count", 32'(s_count), 32'(n));
      chk("s_full",  32'(s_full),  32'(n == DP));
      chk("s_empty", 32'(s_empty), 32'(n == 0));
      chk("s_af",    32'(s_af),    32'(n >= AF));
      chk("s_ae",    32'(s_ae),    32'(n <= AE));
      chk("s_ovf",   32'(s_ovf),   32'(m_ovf));
      chk("s_unf",   32'(s_unf),   32'(m_unf));
      chk("s_dout",  32'(s_dout),  32'(m_dout));
      chk("f_count", 32'(f_count), 32'(n));
      chk("f_full",  32'(f_full),  32'(n == DP));
      chk("f_empty", 32'(f_empty), 32'(n == 0));
      chk("f_af",    32'(f_af),    32'(n >= AF));
      chk("f_ae",    32'(f_ae),    32'(n <= AE));
      chk("f_ovf",   32'(f_ovf),   32'(m_ovf));
      chk("f_unf",   32'(f_unf),   32'(m_unf));
      chk("f_dout",  32'(f_dout),  32'(head));
   endtask

   task automatic model_reset();
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endtask

   // One clock of traffic: the model applies the FIFO rules to the pre-edge occupancy.
   task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
      bit was_full, was_empty;
      wren = w;
      din  = d;
      rden = r;
      @(posedge clk);
      was_full  = (q.size() == DP);
      was_empty = (q.size() == 0);
      m_ovf = w && was_full;
      m_unf = r && was_empty;
      if (r && !was_empty) m_dout = q.pop_front();
      if (w && !was_full)  q.push_back(d);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      wren = 1'b0;
      rden = 1'b0;
      rstn = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      rstn = 1'b1;
      #1;
   endtask

   task automatic drain();
      while (q.size() > 0) step(1'b0, '0, 1'b1);
   endtask

   initial begin
      #2;
      do_reset();

      // Fill through thresholds to full, then one rejected write.
      for (int i = 0; i < 6; i++) step(1'b1, DW'(8'h11 + i), 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
      // Read on empty: underflow, standard dout holds.
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);

      // Pointer wrap.
      for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h31 + i), 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h21 + i), 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

      // Simultaneous read/write at count 3, at full, at empty.
      for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h41 + i), 1'b0);
      step(1'b1, 8'h44, 1'b1);
      step(1'b1, 8'h45, 1'b0);
      step(1'b1, 8'h46, 1'b0);
      step(1'b1, 8'h47, 1'b1);
      drain();
      step(1'b1, 8'h48, 1'b1);
      drain();

      // Reset with data held.
      for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h51 + i), 1'b0);
      do_reset();

      // FWFT head visibility.
      step(1'b1, 8'hA5, 1'b0);
      step(1'b1, 8'h5A, 1'b0);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);

      // Randomised traffic with shifting write/read bias.
      for (int seg = 0; seg < 8; seg++) begin
         int pw, pr;
         pw = $urandom_range(10, 90);
         pr = $urandom_range(10, 90);
         for (int c = 0; c < 60; c++)
            step($urandom_range(0, 99) < pw, DW'($urandom), $urandom_range(0, 99) < pr);
         if (seg == 4) do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
